// File: rtl/tpu_pkg.sv
// Shared widths, accumulator limits and FSM state encoding for the dot-product accumulator.
package tpu_pkg;

  localparam int OP_W      = 8;
  localparam int PROD_W    = 2 * OP_W;
  localparam int ACC_W     = 18;
  localparam int FRAC_BITS = 8;

  localparam logic signed [ACC_W-1:0] ACC_MAX = 18'sh1FFFF;
  localparam logic signed [ACC_W-1:0] ACC_MIN = 18'sh20000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/dot_acc_q10_8_sat_add_acc.sv
// Combinational Q10.8 accumulator + Q8.8 product adder with overflow flag.
// ACC_SATURATE_EN defined: clamp to [ACC_MIN, ACC_MAX]; undefined: two's-complement wrap, flag 0.
module sat_add_acc
  import tpu_pkg::*;
(
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_add,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

`ifdef ACC_SATURATE_EN
  logic [ACC_W:0] w_sum_ext;

  // One guard bit: disagreement between the top two bits means the 18-bit range was left.
  assign w_sum_ext = {i_acc[ACC_W-1], i_acc} + {{(ACC_W+1-PROD_W){i_add[PROD_W-1]}}, i_add};
  assign o_ovf     = w_sum_ext[ACC_W] ^ w_sum_ext[ACC_W-1];
  assign o_sum     = !o_ovf ? w_sum_ext[ACC_W-1:0]
                   : (w_sum_ext[ACC_W] ? ACC_MIN : ACC_MAX);
`else
  assign o_sum = i_acc + {{(ACC_W-PROD_W){i_add[PROD_W-1]}}, i_add};
  assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/dot_acc_q10_8.sv
// Sequential signed Q4.4 x Q4.4 dot-product accumulator with Q10.8 valid/ready result.
// Optional clamping on overflow (sticky ovf) when ACC_SATURATE_EN is defined.
//
//  state    | meaning
//  ST_IDLE  | waiting for start; no input or output handshake
//  ST_ACCUM | accepting operand pairs until VEC_LEN beats have been summed
//  ST_DONE  | result presented on acc_out until out_ready
module dot_acc_q10_8
  import tpu_pkg::*;
#(
  parameter int VEC_LEN = 4,
  parameter int CNT_W   = $clog2(VEC_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;

  logic signed [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]         w_sum;
  logic                     w_sum_ovf;
  logic                     w_beat;

  assign w_prod = $signed(a) * $signed(b);
  assign w_beat = in_valid & in_ready;

  sat_add_acc u_sat_add_acc (
    .i_acc (r_acc),
    .i_add (w_prod),
    .o_sum (w_sum),
    .o_ovf (w_sum_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (w_beat) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1);
            r_ovf <= r_ovf | w_sum_ovf;
            if (r_cnt == LAST_BEAT) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // start arriving with the handshake is dropped: only IDLE honours start.
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_ACCUM) || (r_state == ST_DONE);
  assign acc_out   = r_acc;
  assign ovf       = r_ovf;

endmodule
